// File: rtl/mole_spawner.sv
// Picks a hole and visible/gap durations from the LFSR byte, then resolves each mole as hit or miss.
// One cycle latency: all outputs are registered. The rand port is named rnd because rand is a reserved word.
module mole_spawner #(
    parameter int HOLE_W   = 3,
    parameter int CNT_W    = 16,
    parameter int GAP_BASE = 200,
    parameter int GAP_STEP = 20,
    parameter int UP_BASE  = 300,
    parameter int UP_STEP  = 40,
    localparam int N_HOLES = 2 ** HOLE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               tick,
    input  logic [7:0]         rnd,
    input  logic [N_HOLES-1:0] btn,
    output logic [N_HOLES-1:0] mole,
    output logic               hit,
    output logic               miss,
    output logic               active
);

    typedef enum logic [1:0] {IDLE, GAP, UP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [HOLE_W-1:0]  prev_q, prev_d;
    logic [HOLE_W-1:0]  hole_q, hole_d;
    logic [N_HOLES-1:0] mole_q, mole_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               active_q;

    logic [CNT_W-1:0]   gap_load;
    logic [CNT_W-1:0]   up_load;
    logic [HOLE_W-1:0]  pick;
    logic [HOLE_W-1:0]  spawn_hole;

    assign gap_load = CNT_W'(GAP_BASE) + CNT_W'(rnd[7:4]) * CNT_W'(GAP_STEP);
    assign up_load  = CNT_W'(UP_BASE) + CNT_W'(rnd[7:4]) * CNT_W'(UP_STEP);
    assign pick     = rnd[HOLE_W-1:0];
    // Never show the same hole twice in a row; the increment wraps modulo N_HOLES.
    assign spawn_hole = (pick == prev_q) ? pick + HOLE_W'(1) : pick;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        hole_d  = hole_q;
        mole_d  = mole_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        if (!en) begin
            state_d = IDLE;
            mole_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = GAP;
                    cnt_d   = gap_load;
                end
                GAP: begin
                    if (tick) begin
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = UP;
                            hole_d  = spawn_hole;
                            prev_d  = spawn_hole;
                            mole_d  = N_HOLES'(1) << spawn_hole;
                            cnt_d   = up_load;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                UP: begin
                    // A correct press beats an expiring tick in the same cycle.
                    if (btn[hole_q]) begin
                        hit_d   = 1'b1;
                        mole_d  = '0;
                        state_d = GAP;
                        cnt_d   = gap_load;
                    end else if (tick) begin
                        if (cnt_q == CNT_W'(1)) begin
                            miss_d  = 1'b1;
                            mole_d  = '0;
                            state_d = GAP;
                            cnt_d   = gap_load;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    mole_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            prev_q   <= '0;
            hole_q   <= '0;
            mole_q   <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            hole_q   <= hole_d;
            mole_q   <= mole_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            active_q <= (state_d != IDLE);
        end
    end

    assign mole   = mole_q;
    assign hit    = hit_q;
    assign miss   = miss_q;
    assign active = active_q;

endmodule

// File: tb/tb_mole_spawner.sv
// Randomized and directed bench for mole_spawner against a behavioural game model.
module tb_mole_spawner;

    localparam int HOLE_W = 3;
    localparam int NH     = 8;
    localparam int GB = 2, GS = 1, UB = 3, US = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          tick = 1'b0;
    logic [7:0]    rnd = 8'h01;
    logic [NH-1:0] btn = '0;
    logic [NH-1:0] mole;
    logic          hit, miss, active;

    mole_spawner #(
        .HOLE_W(HOLE_W), .CNT_W(16), .GAP_BASE(GB), .GAP_STEP(GS),
        .UP_BASE(UB), .UP_STEP(US)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .tick(tick), .rnd(rnd), .btn(btn),
        .mole(mole), .hit(hit), .miss(miss), .active(active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Game model: phase 0 = idle, 1 = waiting gap, 2 = mole showing.
    int phase = 0;
    int left = 0;
    int last_hole = 0;
    int cur_hole = 0;
    int e_mole = 0;
    int e_hit = 0;
    int e_miss = 0;
    int hits_seen = 0;
    int misses_seen = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        phase = 0; left = 0; last_hole = 0; cur_hole = 0;
        e_mole = 0; e_hit = 0; e_miss = 0;
    endtask

    task automatic model_edge(input int e, input int t, input int r, input int b);
        int h;
        e_hit = 0;
        e_miss = 0;
        if (e == 0) begin
            phase = 0;
            e_mole = 0;
        end else if (phase == 0) begin
            phase = 1;
            left = GB + (r / 16) * GS;
        end else if (phase == 1) begin
            if (t != 0) begin
                if (left == 1) begin
                    h = r % NH;
                    if (h == last_hole) h = (h + 1) % NH;
                    cur_hole = h;
                    last_hole = h;
                    e_mole = 1 << h;
                    left = UB + (r / 16) * US;
                    phase = 2;
                end else begin
                    left = left - 1;
                end
            end
        end else begin
            if (((b >> cur_hole) & 1) != 0) begin
                e_hit = 1; e_mole = 0; phase = 1;
                left = GB + (r / 16) * GS;
            end else if (t != 0) begin
                if (left == 1) begin
                    e_miss = 1; e_mole = 0; phase = 1;
                    left = GB + (r / 16) * GS;
                end else begin
                    left = left - 1;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".mole"}, int'(mole), e_mole);
        check({tag, ".hit"}, int'(hit), e_hit);
        check({tag, ".miss"}, int'(miss), e_miss);
        check({tag, ".active"}, int'(active), (phase != 0) ? 1 : 0);
        if (hit === 1'b1) hits_seen++;
        if (miss === 1'b1) misses_seen++;
    endtask

    task automatic step(input logic e, input logic t, input logic [7:0] r,
                        input logic [NH-1:0] b, input string tag);
        @(negedge clk);
        en = e; tick = t; rnd = r; btn = b;
        @(posedge clk);
        model_edge(int'(e), int'(t), int'(r), int'(b));
        #1;
        compare_all(tag);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check({tag, ".mole"}, int'(mole), 0);
        check({tag, ".hit"}, int'(hit), 0);
        check({tag, ".miss"}, int'(miss), 0);
        check({tag, ".active"}, int'(active), 0);
        en = 1'b0; tick = 1'b0; btn = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Tick through the gap until the model shows a mole, spawning with r.
    task automatic spawn(input logic [7:0] r, input string tag);
        int n = 0;
        while (phase != 2 && n < 100) begin
            step(1'b1, 1'b1, r, '0, tag);
            n++;
        end
        check({tag, ".spawn_timeout"}, (phase == 2) ? 1 : 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        #12 rst = 1'b0;
        model_reset();

        async_reset("rst_idle");

        // Spawn: rand 0x25 loads a 4-tick gap, 0x13 on the 4th tick shows hole 3 for 4 ticks.
        step(1'b1, 1'b0, 8'h25, '0, "start");
        check("start.gap_cnt", left, 4);
        step(1'b1, 1'b1, 8'h11, '0, "gap1");
        step(1'b1, 1'b1, 8'h11, '0, "gap2");
        step(1'b1, 1'b1, 8'h11, '0, "gap3");
        step(1'b1, 1'b1, 8'h13, '0, "gap4");
        check("spawn.mole", int'(mole), 8'h08);
        check("spawn.active", int'(active), 1);
        check("spawn.up_cnt", left, 4);

        // Hit: wrong hole ignored, right hole hits.
        step(1'b1, 1'b0, 8'h11, 8'h01, "wrong_btn");
        check("wrong_btn.mole", int'(mole), 8'h08);
        step(1'b1, 1'b0, 8'h31, 8'h08, "right_btn");
        check("right_btn.hit", int'(hit), 1);
        check("right_btn.mole", int'(mole), 0);
        step(1'b1, 1'b0, 8'h11, '0, "after_hit");
        check("after_hit.hit", int'(hit), 0);

        // Miss: bring hole 3 back via hole 2, then let it time out.
        spawn(8'h12, "via2");
        step(1'b1, 1'b0, 8'h11, 8'h04, "hit2");
        spawn(8'h13, "up3");
        check("up3.mole", int'(mole), 8'h08);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h11, '0, "count");
        check("pre_miss.mole", int'(mole), 8'h08);
        step(1'b1, 1'b1, 8'h11, '0, "tick4");
        check("miss.pulse", int'(miss), 1);
        check("miss.mole", int'(mole), 0);

        // Correct button on the final tick: hit wins.
        spawn(8'h12, "via2b");
        step(1'b1, 1'b0, 8'h11, 8'h04, "hit2b");
        spawn(8'h13, "up3b");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h11, '0, "countb");
        step(1'b1, 1'b1, 8'h11, 8'h08, "tie");
        check("tie.hit", int'(hit), 1);
        check("tie.miss", int'(miss), 0);

        // Repeat avoidance: 3 -> 4, then 7, then 7 -> 0.
        spawn(8'h03, "rep3");
        check("rep3.mole", int'(mole), 8'h10);
        step(1'b1, 1'b0, 8'h11, 8'h10, "hit4");
        spawn(8'h07, "up7");
        check("up7.mole", int'(mole), 8'h80);
        step(1'b1, 1'b0, 8'h11, 8'h80, "hit7");
        spawn(8'h07, "rep7");
        check("rep7.mole", int'(mole), 8'h01);

        // Enable drop on the final tick with the correct button held.
        while (left != 1) step(1'b1, 1'b1, 8'h11, '0, "drain");
        step(1'b0, 1'b1, 8'h11, 8'h01, "drop");
        check("drop.mole", int'(mole), 0);
        check("drop.miss", int'(miss), 0);
        check("drop.hit", int'(hit), 0);
        check("drop.active", int'(active), 0);
        step(1'b1, 1'b0, 8'h25, '0, "reen");
        check("reen.active", int'(active), 1);
        check("reen.gap_cnt", left, 4);

        // Reset mid-UP with hole 3 showing.
        spawn(8'h02, "pre_r");
        step(1'b1, 1'b0, 8'h11, 8'h04, "hit_r");
        spawn(8'h13, "up_r");
        check("up_r.mole", int'(mole), 8'h08);
        async_reset("rst_up");
        step(1'b0, 1'b1, 8'h11, '0, "post_rst");

        // Random play.
        hits_seen = 0;
        misses_seen = 0;
        for (int i = 0; i < 4000; i++) begin
            logic e, t;
            logic [7:0] r;
            logic [NH-1:0] b;
            e = ($urandom_range(0, 99) < 96);
            t = ($urandom_range(0, 1) == 1);
            r = 8'($urandom_range(1, 255));
            b = '0;
            case ($urandom_range(0, 9))
                0: b = 8'($urandom);
                1, 2: b = NH'(e_mole);
                default: b = '0;
            endcase
            step(e, t, r, b, "rnd");
        end
        check("rnd.hits_seen", (hits_seen > 0) ? 1 : 0, 1);
        check("rnd.misses_seen", (misses_seen > 0) ? 1 : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mole_spawner.md
Name: mole_spawner

Overview:
- Consumes the free-running 8-bit pseudo-random byte from the LFSR stage and decides which hole shows a mole, and for how long.
- Decides how long the gap before the next mole lasts.
- Resolves each mole as a hit or a miss from debounced button pulses.
- Sits between the LFSR and the display/scoring logic.

Parameters:
HOLE_W, 3, hole index width; N_HOLES = 2**HOLE_W; legal 1..4
CNT_W, 16, width of the tick countdown counter
GAP_BASE, 200, minimum gap length in ticks; must be >= 1
GAP_STEP, 20, extra gap ticks per unit of rand[7:4]
UP_BASE, 300, minimum mole-visible time in ticks; must be >= 1
UP_STEP, 40, extra visible ticks per unit of rand[7:4]
Constraint: BASE + 15*STEP < 2**CNT_W for both the gap and visible timers.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
en  input  1  game running; level
tick  input  1  single-cycle timebase strobe (e.g. 1 ms)
rand  input  8  pseudo-random byte from LFSR, changes every clk
btn  input  N_HOLES  debounced single-cycle press pulses, bit i = hole i
mole  output  N_HOLES  one-hot visible mole, or all zero
hit  output  1  one-cycle pulse: correct hole pressed while mole up
miss  output  1  one-cycle pulse: mole timed out unhit
active  output  1  high while state != IDLE

Behaviour:
- Reset (async, any time): state=IDLE, cnt=0, prev_hole=0, mole=0, hit=0, miss=0, active=0. All outputs are registered.
- States are IDLE, GAP and UP. Every transition and output change below takes effect at the sampling clk edge, so outputs show it in the following cycle.
- IDLE:
  - en=0: stay in IDLE.
  - en=1: go to GAP and load cnt = GAP_BASE + rand[7:4]*GAP_STEP, using the rand sampled at that edge.
- GAP:
  - On tick with cnt>1: decrement cnt.
  - On tick with cnt==1: go to UP.
    - hole = rand[HOLE_W-1:0]; if hole == prev_hole, use hole+1 mod N_HOLES instead.
    - Set mole = one-hot(hole), prev_hole = hole.
    - Load cnt = UP_BASE + rand[7:4]*UP_STEP.
  - btn is ignored in GAP.
- UP:
  - btn[hole]=1: hit=1 for exactly one cycle, mole=0, go to GAP and reload the gap counter from the current rand.
  - Else, tick with cnt==1: miss=1 for one cycle, mole=0, go to GAP and reload the gap counter.
  - Else, tick: decrement cnt.
  - btn bits for other holes are ignored; no penalty.
- Simultaneous events:
  - Correct btn and final tick in the same cycle: hit wins, miss stays 0.
  - Multiple btn bits including the correct one: counts as a hit.
- en=0 in any state has highest priority:
  - Next state is IDLE and mole goes to 0.
  - No hit or miss is generated, even if btn or an expiring tick coincides.
  - prev_hole is retained.
  - Re-asserting en starts a fresh GAP.
- hit and miss are never asserted together. At most one of them per mole.
- rand is sampled only at load edges, with no internal copy. The LFSR never outputs 0, so this block needs no zero handling.

Test Plan (bench params: GAP_BASE=2, GAP_STEP=1, UP_BASE=3, UP_STEP=1, HOLE_W=3; rand driven directly):
1. Reset:
   - From IDLE: assert rst asynchronously -> mole=0, hit=0, miss=0, active=0 before the next clk edge.
   - Mid-UP with mole=8'h08: same response, with no miss pulse.
2. Spawn:
   - en=1 with rand=8'h25 -> GAP, cnt=4.
   - After the 4th tick, with rand=8'h13 -> mole=8'h08, cnt=4, active=1.
3. Hit:
   - mole=8'h08, press btn=8'h01 -> ignored.
   - Then press btn=8'h08 -> hit=1 for one cycle, mole=8'h00 the next cycle, GAP reloaded from rand.
4. Miss:
   - mole=8'h08, no btn for 4 ticks -> miss=1 one cycle after the 4th tick, mole=0.
   - Same, but btn=8'h08 on the 4th tick's cycle -> hit=1, miss=0.
5. Repeat avoidance:
   - prev_hole=3, spawn with rand=8'h03 -> mole=8'h10.
   - prev_hole=7, spawn with rand=8'h07 -> mole=8'h01.
6. Enable drop:
   - en=0 during UP, coinciding with the final tick -> state IDLE, mole=0 next cycle, miss stays 0, active=0.
   - Re-enable -> GAP loaded from rand.
